// File: rtl/rf_arbiter.sv
// ---------------------------------------------------------------------------
// rf_arbiter
// Shares a single-port register file between two requesters. Requester 0 is
// normally the command controller and requester 1 a config/debug master.
// Only one transaction is in flight at a time. When both requesters are
// pending, a round-robin pointer picks the winner. The register file strobes
// come straight from registered state. Read data is returned to the winner.
// A read that gets no answer within RD_TIMEOUT cycles finishes with an error.
//
// Ports
//   CLK, RST               clock; asynchronous active-high reset
//   REQn_VLD/WR/ADDR/WDATA request from requester n (held until REQn_GNT)
//   REQn_GNT               one-cycle pulse when requester n's transaction issues
//   REQn_RDATA             last read data returned to requester n (held)
//   REQn_RDATA_VLD         one-cycle read-return pulse
//   REQn_ERR               pulses together with REQn_RDATA_VLD on read timeout
//   BUSY                   high whenever the FSM is not in IDLE
//   RF_WrEn/RdEn           register file write / read strobes
//   RF_Address/RF_WrData   register file address / write data (hold last value)
//   RF_RdData/RF_RdData_VLD register file read return
// ---------------------------------------------------------------------------
module rf_arbiter #(
    parameter int D_WIDTH    = 8,
    parameter int ADDRESS    = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RST,

    input  logic               REQ0_VLD,
    input  logic               REQ0_WR,
    input  logic [ADDRESS-1:0] REQ0_ADDR,
    input  logic [D_WIDTH-1:0] REQ0_WDATA,
    output logic               REQ0_GNT,
    output logic [D_WIDTH-1:0] REQ0_RDATA,
    output logic               REQ0_RDATA_VLD,
    output logic               REQ0_ERR,

    input  logic               REQ1_VLD,
    input  logic               REQ1_WR,
    input  logic [ADDRESS-1:0] REQ1_ADDR,
    input  logic [D_WIDTH-1:0] REQ1_WDATA,
    output logic               REQ1_GNT,
    output logic [D_WIDTH-1:0] REQ1_RDATA,
    output logic               REQ1_RDATA_VLD,
    output logic               REQ1_ERR,

    output logic               BUSY,

    output logic               RF_WrEn,
    output logic               RF_RdEn,
    output logic [ADDRESS-1:0] RF_Address,
    output logic [D_WIDTH-1:0] RF_WrData,
    input  logic [D_WIDTH-1:0] RF_RdData,
    input  logic               RF_RdData_VLD
);

    localparam int              CW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_ptr;     // requester that wins the next tie
    logic          r_sel;     // requester owning the current transaction
    logic          r_wr;      // current transaction is a write
    logic [CW-1:0] r_cnt;     // WAIT_RD cycles seen without read data

    logic               w_any;
    logic               w_pick;
    logic               w_wr;
    logic [ADDRESS-1:0] w_addr;
    logic [D_WIDTH-1:0] w_wdata;

    // A lone requester wins outright. On a tie the pointer decides.
    assign w_any   = REQ0_VLD | REQ1_VLD;
    assign w_pick  = (REQ0_VLD & REQ1_VLD) ? r_ptr : REQ1_VLD;
    assign w_wr    = w_pick ? REQ1_WR    : REQ0_WR;
    assign w_addr  = w_pick ? REQ1_ADDR  : REQ0_ADDR;
    assign w_wdata = w_pick ? REQ1_WDATA : REQ0_WDATA;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= IDLE;
            r_ptr          <= 1'b0;
            r_sel          <= 1'b0;
            r_wr           <= 1'b0;
            r_cnt          <= '0;
            REQ0_GNT       <= 1'b0;
            REQ0_RDATA     <= '0;
            REQ0_RDATA_VLD <= 1'b0;
            REQ0_ERR       <= 1'b0;
            REQ1_GNT       <= 1'b0;
            REQ1_RDATA     <= '0;
            REQ1_RDATA_VLD <= 1'b0;
            REQ1_ERR       <= 1'b0;
            BUSY           <= 1'b0;
            RF_WrEn        <= 1'b0;
            RF_RdEn        <= 1'b0;
            RF_Address     <= '0;
            RF_WrData      <= '0;
        end else begin
            // Pulse outputs default low; each state raises what it needs.
            REQ0_GNT       <= 1'b0;
            REQ1_GNT       <= 1'b0;
            REQ0_RDATA_VLD <= 1'b0;
            REQ1_RDATA_VLD <= 1'b0;
            REQ0_ERR       <= 1'b0;
            REQ1_ERR       <= 1'b0;
            RF_WrEn        <= 1'b0;
            RF_RdEn        <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        // The winner's request is captured straight into the
                        // RF address/data registers. They are only loaded here,
                        // so they keep the last issued values while idle.
                        r_sel      <= w_pick;
                        r_ptr      <= ~w_pick;
                        r_wr       <= w_wr;
                        RF_Address <= w_addr;
                        RF_WrData  <= w_wdata;
                        REQ0_GNT   <= ~w_pick;
                        REQ1_GNT   <= w_pick;
                        RF_WrEn    <= w_wr;
                        RF_RdEn    <= ~w_wr;
                        BUSY       <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (r_wr) begin
                        BUSY    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    // Valid data is checked before the timeout. Data that
                    // arrives on the final cycle is therefore still accepted.
                    if (RF_RdData_VLD) begin
                        if (r_sel) begin
                            REQ1_RDATA     <= RF_RdData;
                            REQ1_RDATA_VLD <= 1'b1;
                        end else begin
                            REQ0_RDATA     <= RF_RdData;
                            REQ0_RDATA_VLD <= 1'b1;
                        end
                        BUSY    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == TO_LAST) begin
                        if (r_sel) begin
                            REQ1_RDATA     <= '0;
                            REQ1_RDATA_VLD <= 1'b1;
                            REQ1_ERR       <= 1'b1;
                        end else begin
                            REQ0_RDATA     <= '0;
                            REQ0_RDATA_VLD <= 1'b1;
                            REQ0_ERR       <= 1'b1;
                        end
                        BUSY    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    BUSY    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
module tb_rf_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int RD_TO = 15;

    logic          CLK;
    logic          RST;
    logic          REQ0_VLD, REQ0_WR, REQ0_GNT, REQ0_RDATA_VLD, REQ0_ERR;
    logic [AW-1:0] REQ0_ADDR;
    logic [DW-1:0] REQ0_WDATA, REQ0_RDATA;
    logic          REQ1_VLD, REQ1_WR, REQ1_GNT, REQ1_RDATA_VLD, REQ1_ERR;
    logic [AW-1:0] REQ1_ADDR;
    logic [DW-1:0] REQ1_WDATA, REQ1_RDATA;
    logic          BUSY, RF_WrEn, RF_RdEn, RF_RdData_VLD;
    logic [AW-1:0] RF_Address;
    logic [DW-1:0] RF_WrData, RF_RdData;

    rf_arbiter #(.D_WIDTH(DW), .ADDRESS(AW), .RD_TIMEOUT(RD_TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VLD(REQ0_VLD), .REQ0_WR(REQ0_WR), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ0_GNT(REQ0_GNT), .REQ0_RDATA(REQ0_RDATA), .REQ0_RDATA_VLD(REQ0_RDATA_VLD), .REQ0_ERR(REQ0_ERR),
        .REQ1_VLD(REQ1_VLD), .REQ1_WR(REQ1_WR), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .REQ1_GNT(REQ1_GNT), .REQ1_RDATA(REQ1_RDATA), .REQ1_RDATA_VLD(REQ1_RDATA_VLD), .REQ1_ERR(REQ1_ERR),
        .BUSY(BUSY),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected DUT events, in order. is_rd=0: grant, is_rd=1: read return.
    typedef struct {
        bit            is_rd;
        int            req;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            err;
        longint        cyc;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] hold[2];    // RDATA each requester should be holding
    int            rf_lat = 0; // register file answer latency, 0 = never answers
    logic [DW-1:0] rf_data = '0;

    task automatic push(input bit is_rd, input int req, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit err, input longint c);
        exp_t e;
        e.is_rd = is_rd; e.req = req; e.wr = wr; e.addr = a; e.data = d; e.err = err; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic vld, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (id == 0) begin
            REQ0_VLD = vld; REQ0_WR = wr; REQ0_ADDR = a; REQ0_WDATA = d;
        end else begin
            REQ1_VLD = vld; REQ1_WR = wr; REQ1_ADDR = a; REQ1_WDATA = d;
        end
    endtask

    function automatic logic [AW-1:0] c_addr(input int id, input int j);
        return id ? AW'(8 + j) : AW'(j);
    endfunction

    function automatic logic [DW-1:0] c_data(input int id, input int j);
        return id ? DW'(8'h20 + j) : DW'(8'h10 + j);
    endfunction

    task automatic check_zero(input string name);
        logic [63:0] v;
        v = {REQ0_GNT, REQ1_GNT, REQ0_RDATA_VLD, REQ1_RDATA_VLD, REQ0_ERR, REQ1_ERR, BUSY,
             RF_WrEn, RF_RdEn, REQ0_RDATA, REQ1_RDATA, RF_Address, RF_WrData};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL %s: outputs=%h, required all 0", name, v);
        end
    endtask

    task automatic wait_gnt(input int id);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(id ? REQ1_GNT : REQ0_GNT) && n < 20);
        if (!(id ? REQ1_GNT : REQ0_GNT)) begin
            n_cmp++; n_bad++;
            $display("FAIL gnt_wait: req%0d GNT=0 after 20 cycles, required 1", id);
        end
    endtask

    task automatic wait_ret(input int id);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(id ? REQ1_RDATA_VLD : REQ0_RDATA_VLD) && n < 40);
        if (!(id ? REQ1_RDATA_VLD : REQ0_RDATA_VLD)) begin
            n_cmp++; n_bad++;
            $display("FAIL ret_wait: req%0d RDATA_VLD=0 after 40 cycles, required 1", id);
        end
    endtask

    // Read by requester id. Grant is expected on the next edge; the return
    // comes lat+1 cycles after the grant, or RD_TO+1 cycles on timeout.
    task automatic do_read(input int id, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int lat, input logic [DW-1:0] rd, input bit exp_err);
        longint g;
        rf_lat  = lat;
        rf_data = rd;
        g = cyc + 1;
        push(0, id, 0, a, wd, 0, g);
        push(1, id, 0, a, exp_err ? '0 : rd, exp_err, exp_err ? g + RD_TO + 1 : g + lat + 1);
        set_req(id, 1, 0, a, wd);
        wait_gnt(id);
        set_req(id, 0, 0, '0, '0);
        wait_ret(id);
        @(negedge CLK);
    endtask

    // Both requesters keep writing until each has had n_each grants. Grants
    // must alternate, starting with 'first', one every two cycles.
    task automatic contend(input int n_each, input int first);
        longint c0;
        int     j[2];
        int     id;
        c0 = cyc;
        for (int i = 0; i < 2 * n_each; i++) begin
            id = (first + i) % 2;
            push(0, id, 1, c_addr(id, i / 2), c_data(id, i / 2), 0, c0 + 1 + 2 * i);
        end
        j[0] = 0; j[1] = 0;
        set_req(0, 1, 1, c_addr(0, 0), c_data(0, 0));
        set_req(1, 1, 1, c_addr(1, 0), c_data(1, 0));
        for (int t = 0; t < 8 * n_each + 8 && (j[0] < n_each || j[1] < n_each); t++) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                if (k ? REQ1_GNT : REQ0_GNT) begin
                    j[k]++;
                    if (j[k] >= n_each) set_req(k, 0, 0, '0, '0);
                    else                set_req(k, 1, 1, c_addr(k, j[k]), c_data(k, j[k]));
                end
            end
        end
        if (j[0] < n_each || j[1] < n_each) begin
            n_cmp++; n_bad++;
            $display("FAIL contend_wait: grants r0=%0d r1=%0d, required %0d each", j[0], j[1], n_each);
            set_req(0, 0, 0, '0, '0);
            set_req(1, 0, 0, '0, '0);
        end
        @(negedge CLK);
    endtask

    // Register file model: answers a read strobe after rf_lat cycles.
    initial begin
        RF_RdData_VLD = 1'b0;
        RF_RdData     = '0;
        forever begin
            @(negedge CLK);
            if (RF_RdEn === 1'b1 && rf_lat > 0) begin
                repeat (rf_lat) @(negedge CLK);
                RF_RdData     = rf_data;
                RF_RdData_VLD = 1'b1;
                @(negedge CLK);
                RF_RdData_VLD = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a return.
    exp_t          me;
    int            mid;
    logic [DW-1:0] m_dat, m_oth;
    logic          m_err;
    always @(negedge CLK) begin
        if (REQ0_GNT || REQ1_GNT) begin
            mid = REQ1_GNT ? 1 : 0;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL grant_unexp: req%0d granted at cyc %0d, no grant required", mid, cyc);
            end else begin
                me = q.pop_front();
                if (me.is_rd || (REQ0_GNT && REQ1_GNT) || mid != me.req || RF_WrEn !== me.wr ||
                    RF_RdEn !== !me.wr || RF_Address !== me.addr || RF_WrData !== me.data ||
                    cyc != me.cyc || BUSY !== 1'b1) begin
                    n_bad++;
                    $display("FAIL grant: got g0=%b g1=%b we=%b re=%b a=%h d=%h busy=%b cyc=%0d; required ret=%b req%0d we=%b a=%h d=%h busy=1 cyc=%0d",
                             REQ0_GNT, REQ1_GNT, RF_WrEn, RF_RdEn, RF_Address, RF_WrData, BUSY, cyc,
                             me.is_rd, me.req, me.wr, me.addr, me.data, me.cyc);
                end
            end
        end
        if (REQ0_RDATA_VLD || REQ1_RDATA_VLD) begin
            mid   = REQ1_RDATA_VLD ? 1 : 0;
            m_dat = mid ? REQ1_RDATA : REQ0_RDATA;
            m_oth = mid ? REQ0_RDATA : REQ1_RDATA;
            m_err = mid ? REQ1_ERR : REQ0_ERR;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL ret_unexp: req%0d RDATA_VLD at cyc %0d (err=%b), no return required", mid, cyc, m_err);
            end else begin
                me = q.pop_front();
                if (!me.is_rd || (REQ0_RDATA_VLD && REQ1_RDATA_VLD) || mid != me.req ||
                    m_dat !== me.data || m_err !== me.err || m_oth !== hold[1 - mid] ||
                    cyc != me.cyc || BUSY !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ret: got v0=%b v1=%b data=%h err=%b other=%h busy=%b cyc=%0d; required ret=%b req%0d data=%h err=%b other=%h busy=0 cyc=%0d",
                             REQ0_RDATA_VLD, REQ1_RDATA_VLD, m_dat, m_err, m_oth, BUSY, cyc,
                             me.is_rd, me.req, me.data, me.err, hold[1 - me.req], me.cyc);
                end
                hold[me.req] = me.data;
            end
        end
        if ((RF_WrEn || RF_RdEn) && !(REQ0_GNT || REQ1_GNT)) begin
            n_cmp++; n_bad++;
            $display("FAIL strobe: we=%b re=%b without grant at cyc %0d, required 0", RF_WrEn, RF_RdEn, cyc);
        end
        if ((REQ0_ERR && !REQ0_RDATA_VLD) || (REQ1_ERR && !REQ1_RDATA_VLD)) begin
            n_cmp++; n_bad++;
            $display("FAIL err_alone: err0=%b err1=%b without RDATA_VLD at cyc %0d, required 0", REQ0_ERR, REQ1_ERR, cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        hold[0] = '0;
        hold[1] = '0;
        RST = 1'b1;
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 1, 4'h5, 8'h3C);

        // Reset holds every output at 0 even with a request pending.
        repeat (3) @(negedge CLK);
        check_zero("reset_outputs");

        // Single write issues on the first edge after release.
        push(0, 0, 1, 4'h5, 8'h3C, 0, cyc + 1);
        RST = 1'b0;
        wait_gnt(0);
        set_req(0, 0, 0, '0, '0);
        @(negedge CLK);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL write_idle: BUSY=%b one cycle after write, required 0", BUSY);
        end

        // Pointer now favours requester 1.
        contend(4, 1);

        // Reads by requester 1 with 1- and 3-cycle register file latency.
        do_read(1, 4'h2, 8'h55, 1, 8'hA7, 0);
        do_read(1, 4'h2, 8'h66, 3, 8'h4E, 0);

        // Data on the last allowed cycle wins; then a true timeout.
        do_read(0, 4'hA, 8'h00, RD_TO, 8'h96, 0);
        do_read(0, 4'hB, 8'h01, 0, 8'hFF, 1);

        // Reset during WAIT_RD discards the read and clears the pointer.
        rf_lat  = 4;
        rf_data = 8'hE1;
        push(0, 0, 0, 4'h3, 8'h77, 0, cyc + 1);
        set_req(0, 1, 0, 4'h3, 8'h77);
        wait_gnt(0);
        set_req(0, 0, 0, '0, '0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        hold[0] = '0;
        hold[1] = '0;
        #1;
        check_zero("reset_in_wait_rd");
        @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        contend(1, 0);

        repeat (3) @(negedge CLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expected events never seen, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
